// File: rtl/inst_fetch_resp.sv
// ---------------------------------------------------------------------------
// inst_fetch_resp
//
// Responder side of the instruction-fetch interface. A small direct-mapped
// instruction cache (one 32-bit word per line) sits between the PC stage /
// IF-ID register and the external instruction memory bus. Lookup is
// combinational, so a hit returns the word in the same cycle. A miss raises
// stallreq_o, refills the line over a req/ack handshake, and the next lookup
// of that address hits.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          synchronous reset, active high
//   pc_i         fetch address from the PC stage (bits [1:0] ignored)
//   ce_i         fetch chip-enable (1 = fetch)
//   inst_o       instruction word to IF-ID (0 when not hitting)
//   stallreq_o   stall request to ctrl (1 = hold PC / IF)
//   mem_addr_o   word-aligned refill address
//   mem_req_o    refill request, held until acknowledged
//   mem_ack_i    memory acknowledge, one-cycle pulse, data valid same cycle
//   mem_rdata_i  refill data
//   hit_cnt_o    (ICACHE_STATS_EN only) saturating hit counter
//   miss_cnt_o   (ICACHE_STATS_EN only) saturating miss counter
//
// Optional feature: define ICACHE_STATS_EN to add the hit/miss counters.
// ---------------------------------------------------------------------------
module inst_fetch_resp #(
   parameter int LINE_BITS = 6,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ce_i,
   output logic [31:0]       inst_o,
   output logic              stallreq_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_req_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int LINES = 1 << LINE_BITS;
   localparam int TAG_W = ADDR_W - LINE_BITS - 2;

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_t;

   state_t state_reg, state_next;

   // Storage. Data and tag arrays are never reset; only the valid bits are.
   logic [31:0]      data_mem [LINES];
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [LINES-1:0] valid_reg;

   // Latched refill address (word aligned, low two bits kept out of storage)
   logic [ADDR_W-3:0] mem_addr_reg;
   logic              mem_req_reg;

   // Lookup fields of the current fetch address
   logic [LINE_BITS-1:0] idx;
   logic [TAG_W-1:0]     tag;
   logic                 hit;

   // Line addressed by the outstanding refill
   logic [LINE_BITS-1:0] refill_idx;
   logic [TAG_W-1:0]     refill_tag;

   // Control strobes from the next-state logic
   logic start_refill;
   logic finish_refill;

   // The byte offset of the fetch address carries no information here
   logic unused_pc_bits;
   assign unused_pc_bits = ^pc_i[1:0];

   assign idx        = pc_i[LINE_BITS+1:2];
   assign tag        = pc_i[ADDR_W-1:LINE_BITS+2];
   assign refill_idx = mem_addr_reg[LINE_BITS-1:0];
   assign refill_tag = mem_addr_reg[ADDR_W-3:LINE_BITS];

   assign hit = ce_i & valid_reg[idx] & (tag_mem[idx] == tag);

   assign mem_addr_o = {mem_addr_reg, 2'b00};
   assign mem_req_o  = mem_req_reg;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      inst_o        = 32'h0;
      stallreq_o    = 1'b0;
      start_refill  = 1'b0;
      finish_refill = 1'b0;

      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (hit) begin
                  inst_o = data_mem[idx];
               end else if (ce_i) begin
                  stallreq_o   = 1'b1;
                  start_refill = 1'b1;
                  state_next   = REFILL;
               end
            end
            REFILL: begin
               // A disabled fetch never stalls, but the refill in flight
               // still runs to completion.
               stallreq_o = ce_i;
               if (mem_ack_i) begin
                  finish_refill = 1'b1;
                  state_next    = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Memory request / address registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_reg  <= 1'b0;
         mem_addr_reg <= '0;
      end else if (start_refill) begin
         mem_req_reg  <= 1'b1;
         mem_addr_reg <= pc_i[ADDR_W-1:2];
      end else if (finish_refill) begin
         mem_req_reg  <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Valid bits, one register per line
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg[gi] <= 1'b0;
            end else if (finish_refill && (refill_idx == LINE_BITS'(gi))) begin
               valid_reg[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Data / tag arrays. A refill overwrites its line unconditionally.
   // finish_refill is already suppressed while rst is high.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (finish_refill) begin
         data_mem[refill_idx] <= mem_rdata_i;
         tag_mem[refill_idx]  <= refill_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   // ------------------------------------------------------------------
   // Saturating hit / miss counters
   // ------------------------------------------------------------------
   logic [31:0] hit_cnt_reg;
   logic [31:0] miss_cnt_reg;
   logic        count_hit;

   assign count_hit = !rst && (state_reg == IDLE) && hit && !stallreq_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_reg  <= 32'h0;
         miss_cnt_reg <= 32'h0;
      end else begin
         if (count_hit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
         end
         if (start_refill && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_reg;
   assign miss_cnt_o = miss_cnt_reg;
`endif

endmodule

// File: tb/tb_inst_fetch_resp.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_resp
//
// Directed bench for inst_fetch_resp. Expected instruction words are pushed
// to a scoreboard queue when the refill data (or a replay) is driven and
// popped when the cache returns a hit. Inputs change 1 ns after the rising
// edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_inst_fetch_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic [31:0] inst_o;
   logic        stallreq_o;
   logic [31:0] mem_addr_o;
   logic        mem_req_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   inst_fetch_resp #(.LINE_BITS(6), .ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_i        (pc_i),
      .ce_i        (ce_i),
      .inst_o      (inst_o),
      .stallreq_o  (stallreq_o),
      .mem_addr_o  (mem_addr_o),
      .mem_req_o   (mem_req_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sample point: mid-cycle
   task automatic sample();
      #4;
   endtask

   task automatic check_pop(input string tag);
      logic [31:0] exp;
      if (exp_q.size() == 0) begin
         total_cnt++;
         $error("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         exp = exp_q.pop_front();
         check(tag, inst_o, exp);
      end
   endtask

   // Full miss sequence: miss cycle, request cycle, wait cycles, ack, hit
   task automatic refill(input logic [31:0] pc, input logic [31:0] word, input int wait_cyc);
      step();
      pc_i = pc; ce_i = 1'b1;
      sample();
      check("miss_stall", {31'b0, stallreq_o}, 32'd1);
      check("miss_inst",  inst_o, 32'h0);
      step();
      sample();
      check("req_raised", {31'b0, mem_req_o}, 32'd1);
      check("req_addr",   mem_addr_o, {pc[31:2], 2'b00});
      for (int i = 0; i < wait_cyc; i++) begin
         step();
         sample();
         check("req_held", {31'b0, mem_req_o}, 32'd1);
      end
      step();
      mem_ack_i = 1'b1; mem_rdata_i = word;
      exp_q.push_back(word);
      step();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      sample();
      check("fill_req_low", {31'b0, mem_req_o}, 32'd0);
      check("fill_stall",   {31'b0, stallreq_o}, 32'd0);
      check_pop("fill_inst");
      $display("refill pc=%h word=%h wait=%0d", pc, word, wait_cyc);
   endtask

   task automatic hit(input logic [31:0] pc, input logic [31:0] word);
      step();
      pc_i = pc; ce_i = 1'b1;
      exp_q.push_back(word);
      sample();
      check("hit_stall", {31'b0, stallreq_o}, 32'd0);
      check("hit_req",   {31'b0, mem_req_o}, 32'd0);
      check_pop("hit_inst");
      $display("hit pc=%h word=%h", pc, word);
   endtask

   task automatic expect_miss(input string tag, input logic [31:0] pc);
      step();
      pc_i = pc; ce_i = 1'b1;
      sample();
      check(tag, {31'b0, stallreq_o}, 32'd1);
      $display("miss pc=%h", pc);
   endtask

   initial begin
      rst = 1'b1; pc_i = 32'h0; ce_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;

      // Reset for two cycles; combinational outputs held low during reset
      step();
      sample();
      check("rst_stall", {31'b0, stallreq_o}, 32'd0);
      check("rst_inst",  inst_o, 32'h0);
      step();
      sample();
      check("rst_req",  {31'b0, mem_req_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'h0);
`ifdef ICACHE_STATS_EN
      check("rst_hits",   hit_cnt_o, 32'd0);
      check("rst_misses", miss_cnt_o, 32'd0);
`endif
      rst = 1'b0;
      $display("reset released");

      // First fetch: miss at 0x0, memory waits 3 cycles
      refill(32'h0, 32'h3401_0001, 3);
      // Sequential fills, then replay
      refill(32'h4, 32'h3402_0002, 1);
      refill(32'h8, 32'h3403_0003, 0);
      hit(32'h0, 32'h3401_0001);
      hit(32'h4, 32'h3402_0002);
      hit(32'h8, 32'h3403_0003);
      // Low address bits are ignored on lookup
      hit(32'h7, 32'h3402_0002);

      // Same-index conflict: 0x100 evicts 0x0, then 0x0 misses again
      refill(32'h100, 32'hAAAA_0100, 1);
      refill(32'h0, 32'h3401_0001, 2);
      expect_miss("conflict_evict", 32'h100);
      refill(32'h100, 32'hAAAA_0100, 0);

      // ce_i low with stray ack while IDLE: outputs quiet, no array write
      step();
      ce_i = 1'b0; pc_i = 32'h40;
      mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
      sample();
      check("ce0_inst",  inst_o, 32'h0);
      check("ce0_stall", {31'b0, stallreq_o}, 32'd0);
      step();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; pc_i = 32'h4;
      sample();
      check("ce0_req",      {31'b0, mem_req_o}, 32'd0);
      check("ce0_hitgated", inst_o, 32'h0);
      $display("idle ack ignored, ce_i low quiet");
      refill(32'h40, 32'h1234_5678, 1);

      // Reset during a refill; a late ack must be ignored
      step();
      pc_i = 32'h200; ce_i = 1'b1;
      sample();
      check("mid_miss", {31'b0, stallreq_o}, 32'd1);
      step();
      sample();
      check("mid_req", {31'b0, mem_req_o}, 32'd1);
      step();
      rst = 1'b1;
      sample();
      check("mid_rst_stall", {31'b0, stallreq_o}, 32'd0);
      step();
      rst = 1'b0; ce_i = 1'b0;
      sample();
      check("mid_rst_req", {31'b0, mem_req_o}, 32'd0);
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_5555;
      sample();
      check("late_ack_req", {31'b0, mem_req_o}, 32'd0);
      step();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      sample();
      check("late_ack_idle", {31'b0, mem_req_o}, 32'd0);
      $display("reset mid-refill, late ack ignored");
      // Previously filled lines were invalidated by the reset
      expect_miss("post_rst_miss4", 32'h4);
      step();
      ce_i = 1'b0;
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 32'h3402_0002;
      step();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      expect_miss("post_rst_miss8", 32'h8);
      step();
      ce_i = 1'b0;
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 32'h3403_0003;
      step();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      hit(32'h4, 32'h3402_0002);
      hit(32'h8, 32'h3403_0003);

      // Counter check: fresh reset, 1 miss, then 3 hit cycles
      step();
      rst = 1'b1; ce_i = 1'b0;
      step();
      rst = 1'b0;
      refill(32'hC, 32'h3404_0004, 1);
      hit(32'hC, 32'h3404_0004);
      hit(32'hC, 32'h3404_0004);
      step();
      ce_i = 1'b0;
      sample();
      check("final_req", {31'b0, mem_req_o}, 32'd0);
`ifdef ICACHE_STATS_EN
      check("stat_misses", miss_cnt_o, 32'd1);
      check("stat_hits",   hit_cnt_o, 32'd3);
      $display("stats hits=%0d misses=%0d", hit_cnt_o, miss_cnt_o);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
- Responder side of the instruction-fetch interface: accepts the fetch address and chip-enable from the PC stage and returns the instruction word.
- Small direct-mapped instruction cache, one 32-bit word per line, sitting between the PC stage / IF-ID register and the external instruction memory bus.
- On a miss it raises a stall request to ctrl, refills from memory over a req/ack handshake, then serves the word.

Parameters:
- LINE_BITS, 6, log2 of line count (64 lines); index = pc_i[LINE_BITS+1:2]
- ADDR_W, 32, fetch address width; tag = pc_i[ADDR_W-1:LINE_BITS+2]

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high (`RstEnable)
- pc_i  input  32  fetch address from PC stage; bits [1:0] ignored
- ce_i  input  1  fetch chip-enable from PC stage (`ChipEnable = 1)
- inst_o  output  32  instruction word to IF-ID
- stallreq_o  output  1  stall request to ctrl (1 = hold PC / IF)
- mem_addr_o  output  32  word-aligned refill address, {pc[31:2],2'b00}
- mem_req_o  output  1  refill request, held until acknowledged
- mem_ack_i  input  1  memory acknowledge, one-cycle pulse, data valid same cycle
- mem_rdata_i  input  32  refill data

Behaviour:
- Storage: data[2^LINE_BITS] x 32, tag array, valid bit per line. FSM states IDLE, REFILL.
- Reset (sync, rst=1 at edge): all valid bits 0, state IDLE, mem_req_o 0, mem_addr_o 0. Combinational outputs during reset: inst_o 0, stallreq_o 0. Data/tag arrays need no reset.
- Lookup is combinational on pc_i: hit = ce_i & valid[idx] & (tag[idx]==pc tag).
- ce_i=0: inst_o=0, stallreq_o=0, no refill started, state unchanged except an in-flight REFILL completes normally.
- IDLE, hit: inst_o=data[idx] in the same cycle, stallreq_o=0. 0-cycle added latency.
- IDLE, miss (ce_i=1): stallreq_o=1 in the same cycle, inst_o=0. At the edge: state<=REFILL, mem_req_o<=1, mem_addr_o<={pc_i[31:2],2'b00} latched.
- REFILL: stallreq_o=1, inst_o=0, mem_req_o held at 1 and mem_addr_o stable until mem_ack_i=1.
  - On the ack edge: write data/tag at the latched address's index, set valid, mem_req_o<=0, state<=IDLE.
  - Next cycle the lookup hits; minimum miss penalty = 2 + memory wait cycles.
- pc_i change during REFILL (e.g. a branch redirect): the refill completes for the latched address; the new pc is looked up in IDLE and may miss again.
- mem_ack_i while IDLE is ignored; no state or array change.
- Same-index conflict: refill overwrites the line unconditionally (direct-mapped replacement).
- Reset asserted mid-REFILL: next edge state IDLE, mem_req_o 0, all lines invalid. A late ack is then ignored.
- Only one outstanding request at a time.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds output ports hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments on each cycle with IDLE & hit & stallreq_o=0.
  - miss_cnt_o increments on each IDLE→REFILL transition.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- rst=1 for 2 cycles, then ce_i=1, pc_i=32'h0 -> cycle 0: stallreq_o=1. Cycle 1: mem_req_o=1, mem_addr_o=32'h0. Ack with rdata=32'h34010001 after 3 cycles -> the cycle after the ack, inst_o=32'h34010001, stallreq_o=0.
- Sequential fetch 0x0,0x4,0x8, all refilled, then replay 0x0,0x4,0x8 -> each replay cycle hits, stallreq_o=0, correct words returned, no mem_req_o.
- Conflict: fill 0x0000, then fetch 0x0100 (same index, LINE_BITS=6) -> miss and refill. Refetch 0x0000 -> miss again.
- mem_ack_i pulsed with rdata=32'hDEADBEEF while IDLE, then fetch that address -> still a miss; the pulse did not write the array.
- Raise rst mid-REFILL, then ack one cycle after rst drops -> mem_req_o=0 after the reset edge, ack ignored. A refetch of any earlier-filled address misses.
- ce_i=0 with any pc_i -> inst_o=0, stallreq_o=0, mem_req_o stays 0. With ICACHE_STATS_EN: after 1 miss + 3 hits, miss_cnt_o=1, hit_cnt_o=3.
